knn_vote: RTL and testbench



---
 rtl/knn_vote_pkg.sv | 30 +++
 rtl/knn_vote_hist.sv | 38 +++
 rtl/knn_vote.sv | 128 ++++++++++++
 tb/tb_knn_vote.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/knn_vote_pkg.sv
// Shared sizing constants, FSM encoding and entry decode helper for the kNN
// majority-vote classifier.
package knn_vote_pkg;

  localparam int DATA_W      = 32;
  localparam int LABEL       = 8;
  localparam int N_Neighbour = 10;
  localparam int N_CLASSES   = 16;

  localparam int ENTRY_W = DATA_W + LABEL;
  localparam int CNT_W   = $clog2(N_Neighbour + 1);
  localparam int IDX_W   = $clog2(N_Neighbour);
  localparam int CLS_W   = $clog2(N_CLASSES);

  localparam logic [DATA_W-1:0] EMPTY_DIST = {DATA_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    PICK = 2'd2,
    DONE = 2'd3
  } state_t;

  // An entry votes only if it is occupied and its label maps to a histogram bin.
  function automatic logic entry_valid(input logic [ENTRY_W-1:0] entry);
    return (entry[ENTRY_W-1 -: DATA_W] != EMPTY_DIST) &&
           (entry[LABEL-1:0] < LABEL'(N_CLASSES));
  endfunction

endpackage

// File: rtl/knn_vote_hist.sv
// Per-class vote counters plus the index of the first entry that voted for
// each class; cleared as a block, incremented one class per cycle.
module knn_vote_hist
  import knn_vote_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             inc,
  input  logic [CLS_W-1:0] inc_class,
  input  logic [IDX_W-1:0] inc_index,
  input  logic [CLS_W-1:0] rd_class,
  output logic [CNT_W-1:0] rd_count,
  output logic [IDX_W-1:0] rd_first
);

  logic [CNT_W-1:0] hist  [N_CLASSES];
  logic [IDX_W-1:0] first [N_CLASSES];

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      for (int c = 0; c < N_CLASSES; c++) begin
        hist[c]  <= '0;
        first[c] <= '0;
      end
    end else if (inc) begin
      hist[inc_class] <= hist[inc_class] + CNT_W'(1);
      // Entries are scanned nearest first, so the first hit is the nearest one.
      if (hist[inc_class] == '0) begin
        first[inc_class] <= inc_index;
      end
    end
  end

  assign rd_count = hist[rd_class];
  assign rd_first = first[rd_class];

endmodule

// File: rtl/knn_vote.sv
// Majority-vote classifier over the kNN neighbour list: snapshot, scan the
// entries into a histogram, then argmax with nearest-first tie breaking.
module knn_vote
  import knn_vote_pkg::*;
(
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [ENTRY_W*N_Neighbour-1:0] Neighbour_info,
  output logic                           busy,
  output logic                           done,
  output logic [LABEL-1:0]               label_out,
  output logic [CNT_W-1:0]               votes_out,
  output logic [CNT_W-1:0]               n_valid,
  output logic                           empty
);

  state_t                         state;
  logic [ENTRY_W*N_Neighbour-1:0] snap;
  logic [IDX_W-1:0]               idx;
  logic [CLS_W-1:0]               cls;
  logic [CNT_W-1:0]               valid_cnt;
  logic [CNT_W-1:0]               best_cnt;
  logic [CLS_W-1:0]               best_cls;
  logic [IDX_W-1:0]               best_first;

  logic [ENTRY_W-1:0] cur_entry;
  logic               cur_valid;
  logic [CNT_W-1:0]   rd_count;
  logic [IDX_W-1:0]   rd_first;
  logic               take;

  assign cur_entry = snap[idx*ENTRY_W +: ENTRY_W];
  assign cur_valid = entry_valid(cur_entry);

  // A later-seen class only displaces an equal count when it appeared nearer.
  assign take = (rd_count > best_cnt) ||
                ((rd_count == best_cnt) && (best_cnt != '0) && (rd_first < best_first));

  knn_vote_hist u_hist (
    .clk       (clk),
    .rst       (rst),
    .clear     (state == IDLE),
    .inc       ((state == SCAN) && cur_valid),
    .inc_class (cur_entry[CLS_W-1:0]),
    .inc_index (idx),
    .rd_class  (cls),
    .rd_count  (rd_count),
    .rd_first  (rd_first)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      snap       <= '0;
      idx        <= '0;
      cls        <= '0;
      valid_cnt  <= '0;
      best_cnt   <= '0;
      best_cls   <= '0;
      best_first <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      label_out  <= '0;
      votes_out  <= '0;
      n_valid    <= '0;
      empty      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          // The cycle showing done is still IDLE but must not accept a start.
          if (start && !done) begin
            snap      <= Neighbour_info;
            idx       <= '0;
            valid_cnt <= '0;
            busy      <= 1'b1;
            state     <= SCAN;
          end
        end
        SCAN: begin
          if (cur_valid) begin
            valid_cnt <= valid_cnt + CNT_W'(1);
          end
          if (idx == IDX_W'(N_Neighbour - 1)) begin
            cls        <= '0;
            best_cnt   <= '0;
            best_cls   <= '0;
            best_first <= '0;
            state      <= PICK;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        PICK: begin
          if (take) begin
            best_cnt   <= rd_count;
            best_cls   <= cls;
            best_first <= rd_first;
          end
          if (cls == CLS_W'(N_CLASSES - 1)) begin
            state <= DONE;
          end else begin
            cls <= cls + CLS_W'(1);
          end
        end
        DONE: begin
          done    <= 1'b1;
          busy    <= 1'b0;
          n_valid <= valid_cnt;
          empty   <= (valid_cnt == '0);
          if (valid_cnt == '0) begin
            label_out <= '0;
            votes_out <= '0;
          end else begin
            label_out <= LABEL'(best_cls);
            votes_out <= best_cnt;
          end
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_knn_vote.sv
// Scoreboard bench for knn_vote: directed and random neighbour lists, expected
// results from a plain vote-counting model, checked by a done-driven monitor.
module tb_knn_vote;
  import knn_vote_pkg::*;

  typedef logic [ENTRY_W*N_Neighbour-1:0] list_t;

  typedef struct {
    int lbl;
    int votes;
    int nv;
    int emp;
  } res_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  list_t            info;
  logic             busy;
  logic             done;
  logic [LABEL-1:0] label_out;
  logic [CNT_W-1:0] votes_out;
  logic [CNT_W-1:0] n_valid;
  logic             empty;

  res_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  int l_t1 [N_Neighbour] = '{3, 3, 5, 3, 5, 1, 1, 1, 1, 2};
  int l_t2 [N_Neighbour] = '{5, 2, 2, 5, 7, 0, 0, 0, 0, 0};
  int l_t4 [N_Neighbour] = '{200, 200, 200, 200, 200, 200, 4, 4, 4, 4};
  int l_t5 [N_Neighbour] = '{6, 0, 6, 0, 0, 12, 12, 12, 6, 3};
  int l_nine [N_Neighbour] = '{9, 9, 9, 9, 9, 9, 9, 9, 9, 9};
  int l_rnd [N_Neighbour];

  knn_vote dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .Neighbour_info (info),
    .busy           (busy),
    .done           (done),
    .label_out      (label_out),
    .votes_out      (votes_out),
    .n_valid        (n_valid),
    .empty          (empty)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int got, input int expv);
    checks++;
    if (got != expv) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", name, got, expv);
    end
  endtask

  function automatic list_t mk(input int lab [N_Neighbour], input int empty_mask);
    list_t v;
    logic [DATA_W-1:0] d;
    v = '0;
    for (int i = 0; i < N_Neighbour; i++) begin
      d = empty_mask[i] ? {DATA_W{1'b1}} : DATA_W'($urandom() & 32'h7FFF_FFFF);
      v[i*ENTRY_W +: ENTRY_W] = {d, LABEL'(lab[i])};
    end
    return v;
  endfunction

  // Count votes per class, winner = most votes, ties to the nearest first vote.
  function automatic res_t model(input list_t v);
    int cnt [N_CLASSES];
    int fst [N_CLASSES];
    int best;
    int lab;
    logic [ENTRY_W-1:0] e;
    res_t r;
    r.nv = 0;
    for (int c = 0; c < N_CLASSES; c++) begin
      cnt[c] = 0;
      fst[c] = -1;
    end
    for (int i = 0; i < N_Neighbour; i++) begin
      e   = v[i*ENTRY_W +: ENTRY_W];
      lab = int'(e[LABEL-1:0]);
      if (e[ENTRY_W-1 -: DATA_W] != {DATA_W{1'b1}} && lab < N_CLASSES) begin
        cnt[lab]++;
        if (fst[lab] < 0) fst[lab] = i;
        r.nv++;
      end
    end
    best = -1;
    for (int c = 0; c < N_CLASSES; c++) begin
      if (cnt[c] > 0 && (best < 0 || cnt[c] > cnt[best] ||
                         (cnt[c] == cnt[best] && fst[c] < fst[best])))
        best = c;
    end
    r.emp   = (r.nv == 0) ? 1 : 0;
    r.lbl   = (best < 0) ? 0 : best;
    r.votes = (best < 0) ? 0 : cnt[best];
    return r;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin : monitor
    res_t e;
    if (!rst && done) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done got=1 expected=0");
      end else begin
        e = exp_q.pop_front();
        check("label_out", int'(label_out), e.lbl);
        check("votes_out", int'(votes_out), e.votes);
        check("n_valid", int'(n_valid), e.nv);
        check("empty", int'(empty), e.emp);
      end
    end
  end

  // Issue one request; optionally disturb the inputs mid-run, then await done.
  task automatic run_txn(input list_t v, input bit push, input bit wait_done, input bit disturb);
    int cyc;
    @(negedge clk);
    info  = v;
    start = 1'b1;
    if (push) exp_q.push_back(model(v));
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", int'(busy), 1);
    if (disturb) info = mk(l_nine, 0);
    if (wait_done) begin
      cyc = 0;
      while (!done && cyc < 60) begin
        start = (disturb && cyc == 5) ? 1'b1 : 1'b0;
        @(negedge clk);
        cyc++;
      end
      start = 1'b0;
      check("latency", cyc, N_Neighbour + N_CLASSES + 1);
      check("busy_in_done", int'(busy), 0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout got=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int mask;
    rst   = 1'b1;
    start = 1'b0;
    info  = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_label", int'(label_out), 0);
    check("rst_votes", int'(votes_out), 0);
    check("rst_nvalid", int'(n_valid), 0);
    check("rst_empty", int'(empty), 0);
    rst = 1'b0;

    run_txn(mk(l_t1, 0), 1'b1, 1'b1, 1'b0);
    // A start presented during the done cycle must be dropped.
    start = 1'b1;
    info  = mk(l_t2, 0);
    @(negedge clk);
    start = 1'b0;
    check("start_in_done_ignored", int'(busy), 0);

    run_txn(mk(l_t2, 10'h3E0), 1'b1, 1'b1, 1'b0);
    run_txn(mk(l_t1, 10'h3FF), 1'b1, 1'b1, 1'b0);
    run_txn(mk(l_t4, 0), 1'b1, 1'b1, 1'b0);
    run_txn(mk(l_t5, 10'h010), 1'b1, 1'b1, 1'b1);

    // Reset mid-scan drops the request and clears all outputs.
    run_txn(mk(l_t5, 0), 1'b0, 1'b0, 1'b0);
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy", int'(busy), 0);
    check("midrst_done", int'(done), 0);
    check("midrst_label", int'(label_out), 0);
    check("midrst_votes", int'(votes_out), 0);
    check("midrst_nvalid", int'(n_valid), 0);
    check("midrst_empty", int'(empty), 0);
    run_txn(mk(l_t1, 10'h001), 1'b1, 1'b1, 1'b0);

    for (int t = 0; t < 25; t++) begin
      for (int i = 0; i < N_Neighbour; i++) begin
        case ($urandom_range(0, 11))
          0:       l_rnd[i] = 200;
          1:       l_rnd[i] = $urandom_range(N_CLASSES, N_CLASSES + 3);
          2:       l_rnd[i] = $urandom_range(6, N_CLASSES - 1);
          default: l_rnd[i] = $urandom_range(0, 5);
        endcase
      end
      mask = int'($urandom_range(0, 1023) & $urandom_range(0, 1023));
      run_txn(mk(l_rnd, mask), 1'b1, 1'b1, 1'b0);
    end

    repeat (40) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
